// File: rtl/hall_call_panel.sv
// Hall-call front end: debounces buttons, latches pending calls and
// offers them round-robin to the controller over valid/ready.
module hall_call_panel #(
    parameter int FLOORS          = 5,
    parameter int FLOOR_W         = 3,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  raw_buttons,
    input  logic [FLOOR_W-1:0] current_floor,
    input  logic               door_open,
    output logic               req_valid,
    output logic [FLOOR_W-1:0] req_floor,
    input  logic               req_ready,
    output logic [FLOORS-1:0]  lamps
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic {IDLE, OFFER} state_t;

    logic [FLOORS-1:0]  sync1_q, sync2_q;
    logic [FLOORS-1:0]  db_q, db_dly_q, p_q;
    logic [CW-1:0]      cnt_q [FLOORS];
    logic [FLOORS-1:0]  pend_q, pend_d;
    logic [FLOORS-1:0]  sent_q, sent_d;
    logic [FLOORS-1:0]  svc, elig, sent_set;
    logic [FLOOR_W-1:0] ptr_q, ptr_d;
    logic [FLOOR_W-1:0] req_floor_q, sel_idx;
    logic               req_valid_q, sel_found, accept;
    state_t             state_q;

    always_comb begin
        for (int i = 0; i < FLOORS; i++) begin
            svc[i] = door_open && (current_floor == FLOOR_W'(i));
        end
    end

    assign elig = pend_q & ~sent_q;

    // Scan downward so the last hit is the one closest to ptr.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = FLOORS - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % FLOORS;
            if (elig[idx]) begin
                sel_found = 1'b1;
                sel_idx   = FLOOR_W'(idx);
            end
        end
    end

    assign accept   = (state_q == OFFER) && req_ready && !svc[req_floor_q];
    assign sent_set = accept ? (FLOORS'(1) << req_floor_q) : '0;
    assign pend_d   = (pend_q | p_q) & ~svc;
    assign sent_d   = (sent_q | sent_set) & ~svc;
    assign ptr_d    = (req_floor_q == FLOOR_W'(FLOORS - 1)) ? '0
                                                            : req_floor_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            db_dly_q    <= '0;
            p_q         <= '0;
            for (int i = 0; i < FLOORS; i++) cnt_q[i] <= '0;
            pend_q      <= '0;
            sent_q      <= '0;
            ptr_q       <= '0;
            req_floor_q <= '0;
            req_valid_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            sync1_q  <= raw_buttons;
            sync2_q  <= sync1_q;
            for (int i = 0; i < FLOORS; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        db_q[i]  <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
            db_dly_q <= db_q;
            p_q      <= db_q & ~db_dly_q;
            pend_q   <= pend_d;
            sent_q   <= sent_d;
            unique case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        req_floor_q <= sel_idx;
                        req_valid_q <= 1'b1;
                        state_q     <= OFFER;
                    end
                end
                OFFER: begin
                    if (req_ready) begin
                        ptr_q       <= ptr_d;
                        req_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_floor = req_floor_q;
    assign lamps     = pend_q;

endmodule

// File: tb/tb_hall_call_panel.sv
// Directed bench for hall_call_panel with immediate-assertion checks.
module tb_hall_call_panel;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] raw_buttons;
    logic [2:0] current_floor;
    logic       door_open;
    logic       req_valid;
    logic [2:0] req_floor;
    logic       req_ready;
    logic [4:0] lamps;

    int errors = 0;
    int checks = 0;

    hall_call_panel dut (
        .clk          (clk),
        .reset        (reset),
        .raw_buttons  (raw_buttons),
        .current_floor(current_floor),
        .door_open    (door_open),
        .req_valid    (req_valid),
        .req_floor    (req_floor),
        .req_ready    (req_ready),
        .lamps        (lamps)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, input int max);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            if (req_valid === 1'b1) ok = 1'b1;
            else tick();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        raw_buttons = '0;
        req_ready = 1'b0;
        door_open = 1'b0;
        current_floor = 3'd7;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int seen [$];
        int highs;
        bit prev_v;

        do_reset();
        check("rst_lamps", 32'(lamps), 32'd0);
        check("rst_valid", 32'(req_valid), 32'd0);
        check("rst_floor", 32'(req_floor), 32'd0);

        // Single press on floor 2.
        raw_buttons = 5'b00100;
        for (int n = 0; n < 10; n++) begin
            tick();
            check($sformatf("press_lamps_e%0d", n), 32'(lamps),
                  (n >= 7) ? 32'h04 : 32'h00);
            check($sformatf("press_valid_e%0d", n), 32'(req_valid),
                  (n >= 8) ? 32'd1 : 32'd0);
        end
        raw_buttons = '0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("hold_valid", 32'(req_valid), 32'd1);
            check("hold_floor", 32'(req_floor), 32'd2);
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("accept_drop", 32'(req_valid), 32'd0);
        check("accept_lamps", 32'(lamps), 32'h04);
        for (int n = 0; n < 10; n++) tick();
        check("no_reoffer", 32'(req_valid), 32'd0);
        current_floor = 3'd2;
        door_open = 1'b1;
        tick();
        door_open = 1'b0;
        check("svc2_lamps", 32'(lamps), 32'h00);

        // Glitch on floor 1.
        raw_buttons = 5'b00010;
        tick();
        tick();
        tick();
        raw_buttons = '0;
        for (int n = 0; n < 20; n++) begin
            tick();
            check("glitch_lamps", 32'(lamps), 32'h00);
            check("glitch_valid", 32'(req_valid), 32'd0);
        end

        // Round-robin from ptr=0 over floors 1,3,4.
        do_reset();
        raw_buttons = 5'b11010;
        req_ready = 1'b1;
        highs = 0;
        prev_v = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (req_valid) begin
                seen.push_back(int'(req_floor));
                highs++;
                check("rr_gap", 32'(prev_v), 32'd0);
            end
            prev_v = req_valid;
        end
        req_ready = 1'b0;
        raw_buttons = '0;
        check("rr_count", 32'(highs), 32'd3);
        check("rr_0", (seen.size() > 0) ? 32'(seen[0]) : 32'hff, 32'd1);
        check("rr_1", (seen.size() > 1) ? 32'(seen[1]) : 32'hff, 32'd3);
        check("rr_2", (seen.size() > 2) ? 32'(seen[2]) : 32'hff, 32'd4);
        check("rr_lamps", 32'(lamps), 32'h1a);

        // Service floor 3, then press it again.
        for (int n = 0; n < 10; n++) tick();
        current_floor = 3'd3;
        door_open = 1'b1;
        tick();
        door_open = 1'b0;
        check("svc3_lamps", 32'(lamps), 32'h12);
        raw_buttons = 5'b01000;
        wait_valid("re3_timeout", 20);
        check("re3_floor", 32'(req_floor), 32'd3);
        check("re3_lamps", 32'(lamps), 32'h1a);
        raw_buttons = '0;
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        check("re3_drop", 32'(req_valid), 32'd0);

        // Service while offering floor 2.
        do_reset();
        raw_buttons = 5'b00100;
        wait_valid("sd_timeout", 20);
        raw_buttons = '0;
        check("sd_floor", 32'(req_floor), 32'd2);
        current_floor = 3'd2;
        door_open = 1'b1;
        tick();
        check("sd_lamps", 32'(lamps), 32'h00);
        check("sd_valid", 32'(req_valid), 32'd1);
        check("sd_floor2", 32'(req_floor), 32'd2);
        tick();
        check("sd_valid2", 32'(req_valid), 32'd1);
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        door_open = 1'b0;
        check("sd_drop", 32'(req_valid), 32'd0);
        check("sd_sent", 32'(dut.sent_q[2]), 32'd0);
        for (int n = 0; n < 10; n++) tick();
        check("sd_quiet", 32'(req_valid), 32'd0);

        // Reset while offering with three calls pending.
        raw_buttons = 5'b01011;
        wait_valid("rm_timeout", 20);
        check("rm_lamps", 32'(lamps), 32'h0b);
        reset = 1'b1;
        raw_buttons = '0;
        tick();
        check("rm_valid", 32'(req_valid), 32'd0);
        check("rm_lamps0", 32'(lamps), 32'h00);
        reset = 1'b0;
        for (int n = 0; n < 15; n++) begin
            tick();
            check("rm_quiet", 32'(req_valid), 32'd0);
        end
        check("rm_lamps_end", 32'(lamps), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
